pipe5_fetch2_stage: RTL and testbench
=====================================

PIPE5_FETCH2_STAGE -- requirements
Module: pipe5_fetch2_stage

Interface
REQ-001 SHALL have parameter NOP_INSN, default 32'h0000_0013, the instruction word presented for faulted or misaligned entries.
REQ-002 SHALL have ports, clock and reset first (name  direction  width  meaning):
CLK  in  1  sole clock, rising edge.
nRST  in  1  reset, synchronous, active-low.
f1_valid  in  1  fetch1 presents a PC.
f1_pc  in  32  PC from fetch1.
f1_ready  out  1  fetch2 accepts f1_pc this cycle.
iren  in  1  hazard-unit permission to start a fetch.
fd_stall  in  1  decode not consuming.
fd_flush  in  1  discard all fetch state.
ibus_ren  out  1  instruction bus read request.
ibus_addr  out  32  bus address.
ibus_rdata  in  32  read data, valid when ibus_ren and not ibus_busy.
ibus_busy  in  1  bus not done.
ibus_error  in  1  access fault, qualified like ibus_rdata.
fd_valid  out  1  head entry present to decode.
fd_instr  out  32  head instruction.
fd_pc  out  32  head PC.
f_busy  out  1  request outstanding or draining.
fault_insn  out  1  head entry has an access fault.
mal_insn  out  1  head entry has a misaligned PC.
epc_f  out  32  head PC for exception capture.
badaddr_f  out  32  faulting address of head entry.

Function
REQ-003 SHALL use states IDLE, WAIT and DRAIN, plus a response buffer of DEPTH entries, each holding {pc, instr, fault, mal}.
REQ-004 SHALL drive f1_ready = state==IDLE and iren and not fd_flush and (count<DEPTH or pop).
REQ-005 SHALL define pop = fd_valid and not fd_stall; pop SHALL remove the head at the next edge.
REQ-006 On accept of an aligned PC (f1_pc[1:0]==0), SHALL latch the address and enter WAIT at the next edge.
REQ-007 In WAIT, SHALL hold ibus_ren=1 and ibus_addr stable; in IDLE and DRAIN, ibus_ren=0.
REQ-008 On completion in WAIT (not ibus_busy), SHALL push {addr, ibus_rdata, ibus_error, 0} and return to IDLE at the same edge; fd_valid SHALL rise the cycle after completion (latency 1).
REQ-009 On ibus_error, the pushed instr SHALL be NOP_INSN.
REQ-010 On accept of a misaligned PC, SHALL issue no bus access, push {pc, NOP_INSN, 0, 1} at the next edge, and stay in IDLE.
REQ-011 SHALL allow a simultaneous push and pop, leaving count unchanged; count SHALL never exceed DEPTH or underflow.
REQ-012 SHALL allow at most one outstanding bus request.
REQ-013 On fd_flush: SHALL set count=0 at the next edge; in WAIT without completion, SHALL go to DRAIN; in WAIT with completion, SHALL drop the data and go to IDLE.
REQ-014 In DRAIN, SHALL wait until not ibus_busy, then go to IDLE and discard the data.
REQ-015 SHALL drive f_busy = state!=IDLE.
REQ-016 SHALL drive fd_instr, fd_pc, fault_insn, mal_insn, epc_f and badaddr_f from the head entry; fault_insn and mal_insn SHALL be gated by fd_valid; badaddr_f SHALL equal epc_f.

Reset
REQ-017 When nRST=0 at an edge, SHALL set state=IDLE, count=0 and latched addr=0.
REQ-018 During and after reset, all outputs SHALL be 0 except fd_instr, which SHALL equal NOP_INSN.
REQ-019 Reset in WAIT SHALL abandon the request without entering DRAIN.

Configuration
REQ-020 With macro PIPE5_FETCH_SKID_EN defined, DEPTH SHALL be 2, so one fetch can be issued while one entry is held.
REQ-021 Without PIPE5_FETCH_SKID_EN, DEPTH SHALL be 1.

Structure
REQ-022 SHALL place the fetch2 state enum and the buffer-entry struct in pipe5_types_pkg.
REQ-023 SHALL implement the buffer as sub-module pipe5_fetch_buffer (parameter DEPTH; push/pop/flush; head outputs; count).

Verification
REQ-024 Aligned fetch, busy low 2 cycles: pc=0x100, rdata=0x00500093 -> fd_valid=1, fd_instr=0x00500093, fd_pc=0x100 three cycles after accept.
REQ-025 Misaligned: pc=0x102 -> no ibus_ren; next cycle mal_insn=1, badaddr_f=0x102, fd_instr=0x13.
REQ-026 Bus error at 0x200 -> fault_insn=1, epc_f=0x200, fd_instr=0x13.
REQ-027 fd_flush in WAIT with busy high 3 more cycles -> DRAIN, f_busy=1, then IDLE with fd_valid=0 and the data discarded.
REQ-028 fd_stall held, two PCs offered -> with skid: both accepted, count=2, f1_ready=0; without skid: second not accepted until the stall releases.
REQ-029 nRST=0 mid-WAIT -> next cycle ibus_ren=0, fd_valid=0, f_busy=0.

Source files
------------

// File: rtl/pipe5_types_pkg.sv
// rtl/pipe5_types_pkg.sv - fetch2 state, response-buffer entry type and buffer depth
// Define PIPE5_FETCH_SKID_EN to build a two-entry response buffer; the default is one entry.
package pipe5_types_pkg;

  typedef enum logic [1:0] {
    F2_IDLE  = 2'd0,
    F2_WAIT  = 2'd1,
    F2_DRAIN = 2'd2
  } f2_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic        mal;
  } f2_entry_t;

`ifdef PIPE5_FETCH_SKID_EN
  localparam int F2_DEPTH = 2;
`else
  localparam int F2_DEPTH = 1;
`endif

endpackage

// File: rtl/pipe5_fetch_buffer.sv
// rtl/pipe5_fetch_buffer.sv - shifting response buffer between fetch2 and decode
// Entry 0 is always the head; a pop shifts younger entries down.
module pipe5_fetch_buffer
  import pipe5_types_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       push,
  input  f2_entry_t  push_entry,
  input  logic       pop,
  input  logic       flush,
  output logic       head_valid,
  output f2_entry_t  head,
  output logic [1:0] count
);

  f2_entry_t  mem [DEPTH];
  logic       do_pop;
  logic       do_push;
  logic [1:0] wr_idx;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count < 2'(DEPTH)) || do_pop);
  // With a simultaneous pop the new entry lands one slot lower.
  assign wr_idx  = do_pop ? (count - 2'd1) : count;

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_idx == 2'(i))) begin
        mem[i] <= push_entry;
      end else if (do_pop && (i + 1 < DEPTH)) begin
        mem[i] <= mem[(i + 1) % DEPTH];
      end
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = mem[0];

endmodule

// File: rtl/pipe5_fetch2_stage.sv
// rtl/pipe5_fetch2_stage.sv - fetch2: one outstanding ibus read, responses queued for decode
// Buffer depth is 2 with PIPE5_FETCH_SKID_EN defined, otherwise 1.
module pipe5_fetch2_stage
  import pipe5_types_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        f1_valid,
  input  logic [31:0] f1_pc,
  output logic        f1_ready,
  input  logic        iren,
  input  logic        fd_stall,
  input  logic        fd_flush,
  output logic        ibus_ren,
  output logic [31:0] ibus_addr,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_busy,
  input  logic        ibus_error,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        f_busy,
  output logic        fault_insn,
  output logic        mal_insn,
  output logic [31:0] epc_f,
  output logic [31:0] badaddr_f
);

  f2_state_t   state, state_next;
  logic [31:0] addr;
  logic [1:0]  count;
  logic        pop, accept, aligned, push;
  f2_entry_t   push_entry, head;

  assign pop     = fd_valid && !fd_stall;
  assign aligned = (f1_pc[1:0] == 2'b00);
  assign accept  = f1_valid && f1_ready;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= F2_IDLE;
      addr  <= 32'd0;
    end else begin
      state <= state_next;
      if (accept && aligned) addr <= f1_pc;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      F2_IDLE:  if (accept && aligned) state_next = F2_WAIT;
      F2_WAIT:  if (!ibus_busy) state_next = F2_IDLE;
                else if (fd_flush) state_next = F2_DRAIN;
      F2_DRAIN: if (!ibus_busy) state_next = F2_IDLE;
      default:  state_next = F2_IDLE;
    endcase
  end

  // Reset gates the handshake outputs so they read 0 before the first reset edge too.
  always_comb begin
    f1_ready   = nRST && (state == F2_IDLE) && iren && !fd_flush
                 && ((count < 2'(F2_DEPTH)) || pop);
    ibus_ren   = nRST && (state == F2_WAIT);
    f_busy     = nRST && (state != F2_IDLE);
    push       = 1'b0;
    push_entry = '{pc: f1_pc, instr: NOP_INSN, fault: 1'b0, mal: 1'b1};
    if (state == F2_IDLE && accept && !aligned) begin
      push = 1'b1;
    end else if (state == F2_WAIT && !ibus_busy && !fd_flush) begin
      push       = 1'b1;
      push_entry = '{pc: addr, instr: (ibus_error ? NOP_INSN : ibus_rdata),
                     fault: ibus_error, mal: 1'b0};
    end
  end

  pipe5_fetch_buffer #(
    .DEPTH(F2_DEPTH)
  ) u_buffer (
    .CLK        (CLK),
    .nRST       (nRST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (fd_flush),
    .head_valid (fd_valid),
    .head       (head),
    .count      (count)
  );

  assign ibus_addr  = addr;
  assign fd_instr   = fd_valid ? head.instr : NOP_INSN;
  assign fd_pc      = fd_valid ? head.pc : 32'd0;
  assign fault_insn = fd_valid && head.fault;
  assign mal_insn   = fd_valid && head.mal;
  assign epc_f      = fd_pc;
  assign badaddr_f  = fd_pc;

endmodule

// File: tb/tb_pipe5_fetch2_stage.sv
// tb/tb_pipe5_fetch2_stage.sv - directed self-checking bench for pipe5_fetch2_stage
// Define PIPE5_FETCH_SKID_EN here as for the RTL to check the two-entry build.
module tb_pipe5_fetch2_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        f1_valid;
  logic [31:0] f1_pc;
  logic        f1_ready;
  logic        iren;
  logic        fd_stall;
  logic        fd_flush;
  logic        ibus_ren;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata;
  logic        ibus_busy;
  logic        ibus_error;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        f_busy;
  logic        fault_insn;
  logic        mal_insn;
  logic [31:0] epc_f;
  logic [31:0] badaddr_f;

  int vectors = 0;
  int miscompares = 0;

  pipe5_fetch2_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .f1_valid   (f1_valid),
    .f1_pc      (f1_pc),
    .f1_ready   (f1_ready),
    .iren       (iren),
    .fd_stall   (fd_stall),
    .fd_flush   (fd_flush),
    .ibus_ren   (ibus_ren),
    .ibus_addr  (ibus_addr),
    .ibus_rdata (ibus_rdata),
    .ibus_busy  (ibus_busy),
    .ibus_error (ibus_error),
    .fd_valid   (fd_valid),
    .fd_instr   (fd_instr),
    .fd_pc      (fd_pc),
    .f_busy     (f_busy),
    .fault_insn (fault_insn),
    .mal_insn   (mal_insn),
    .epc_f      (epc_f),
    .badaddr_f  (badaddr_f)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; f1_valid = 1'b1; f1_pc = 32'h100; iren = 1'b1;
    fd_stall = 1'b0; fd_flush = 1'b0; ibus_busy = 1'b1; ibus_rdata = 32'h0; ibus_error = 1'b0;
    cyc(); cyc(); smp();
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL reset.f1_ready got %h want 0", f1_ready); end
    vectors++; if (ibus_ren !== 1'b0) begin miscompares++; $display("FAIL reset.ibus_ren got %h want 0", ibus_ren); end
    vectors++; if (ibus_addr !== 32'h0) begin miscompares++; $display("FAIL reset.ibus_addr got %h want 0", ibus_addr); end
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL reset.fd_valid got %h want 0", fd_valid); end
    vectors++; if (fd_instr !== 32'h13) begin miscompares++; $display("FAIL reset.fd_instr got %h want 00000013", fd_instr); end
    vectors++; if (fd_pc !== 32'h0) begin miscompares++; $display("FAIL reset.fd_pc got %h want 0", fd_pc); end
    vectors++; if (f_busy !== 1'b0) begin miscompares++; $display("FAIL reset.f_busy got %h want 0", f_busy); end
    vectors++; if ({fault_insn, mal_insn} !== 2'b00) begin miscompares++; $display("FAIL reset.fault_mal got %b want 00", {fault_insn, mal_insn}); end
    vectors++; if (badaddr_f !== 32'h0) begin miscompares++; $display("FAIL reset.badaddr_f got %h want 0", badaddr_f); end
    cyc(); nRST = 1'b1; f1_valid = 1'b0;
  endtask

  task automatic test_aligned();
    f1_valid = 1'b1; f1_pc = 32'h100; ibus_busy = 1'b1; smp();
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL aligned.f1_ready got %h want 1", f1_ready); end
    cyc(); f1_valid = 1'b0; smp();
    vectors++; if (ibus_ren !== 1'b1) begin miscompares++; $display("FAIL aligned.ibus_ren got %h want 1", ibus_ren); end
    vectors++; if (ibus_addr !== 32'h100) begin miscompares++; $display("FAIL aligned.ibus_addr got %h want 00000100", ibus_addr); end
    vectors++; if (f_busy !== 1'b1) begin miscompares++; $display("FAIL aligned.f_busy got %h want 1", f_busy); end
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL aligned.f1_ready_wait got %h want 0", f1_ready); end
    cyc(); ibus_busy = 1'b0; ibus_rdata = 32'h0050_0093; smp();
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL aligned.fd_valid_early got %h want 0", fd_valid); end
    vectors++; if (ibus_addr !== 32'h100) begin miscompares++; $display("FAIL aligned.ibus_addr_hold got %h want 00000100", ibus_addr); end
    cyc(); ibus_busy = 1'b1; ibus_rdata = 32'hffff_ffff; smp();
    vectors++; if (fd_valid !== 1'b1) begin miscompares++; $display("FAIL aligned.fd_valid got %h want 1", fd_valid); end
    vectors++; if (fd_instr !== 32'h0050_0093) begin miscompares++; $display("FAIL aligned.fd_instr got %h want 00500093", fd_instr); end
    vectors++; if (fd_pc !== 32'h100) begin miscompares++; $display("FAIL aligned.fd_pc got %h want 00000100", fd_pc); end
    vectors++; if ({ibus_ren, f_busy} !== 2'b00) begin miscompares++; $display("FAIL aligned.idle got %b want 00", {ibus_ren, f_busy}); end
    cyc(); smp();
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL aligned.popped got %h want 0", fd_valid); end
  endtask

  task automatic test_misaligned();
    f1_valid = 1'b1; f1_pc = 32'h102; smp();
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL mal.f1_ready got %h want 1", f1_ready); end
    cyc(); f1_valid = 1'b0; smp();
    vectors++; if ({ibus_ren, f_busy} !== 2'b00) begin miscompares++; $display("FAIL mal.no_bus got %b want 00", {ibus_ren, f_busy}); end
    vectors++; if (mal_insn !== 1'b1) begin miscompares++; $display("FAIL mal.mal_insn got %h want 1", mal_insn); end
    vectors++; if (badaddr_f !== 32'h102) begin miscompares++; $display("FAIL mal.badaddr_f got %h want 00000102", badaddr_f); end
    vectors++; if (fd_instr !== 32'h13) begin miscompares++; $display("FAIL mal.fd_instr got %h want 00000013", fd_instr); end
    vectors++; if (fault_insn !== 1'b0) begin miscompares++; $display("FAIL mal.fault_insn got %h want 0", fault_insn); end
    cyc(); smp();
    vectors++; if ({fd_valid, mal_insn} !== 2'b00) begin miscompares++; $display("FAIL mal.popped got %b want 00", {fd_valid, mal_insn}); end
  endtask

  task automatic test_bus_error();
    f1_valid = 1'b1; f1_pc = 32'h200; ibus_busy = 1'b1;
    cyc(); f1_valid = 1'b0; ibus_busy = 1'b0; ibus_error = 1'b1; ibus_rdata = 32'hdead_beef;
    cyc(); ibus_busy = 1'b1; ibus_error = 1'b0; fd_stall = 1'b1; smp();
    vectors++; if (fault_insn !== 1'b1) begin miscompares++; $display("FAIL err.fault_insn got %h want 1", fault_insn); end
    vectors++; if (epc_f !== 32'h200) begin miscompares++; $display("FAIL err.epc_f got %h want 00000200", epc_f); end
    vectors++; if (fd_instr !== 32'h13) begin miscompares++; $display("FAIL err.fd_instr got %h want 00000013", fd_instr); end
    vectors++; if (mal_insn !== 1'b0) begin miscompares++; $display("FAIL err.mal_insn got %h want 0", mal_insn); end
    cyc(); smp();
    vectors++; if (fault_insn !== 1'b1) begin miscompares++; $display("FAIL err.stall_hold got %h want 1", fault_insn); end
    cyc(); fd_flush = 1'b1; smp();
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL err.ready_in_flush got %h want 0", f1_ready); end
    cyc(); fd_flush = 1'b0; fd_stall = 1'b0; smp();
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL err.flush_clear got %h want 0", fd_valid); end
  endtask

  task automatic test_flush_drain();
    f1_valid = 1'b1; f1_pc = 32'h300; ibus_busy = 1'b1;
    cyc(); f1_valid = 1'b0; fd_flush = 1'b1;
    cyc(); fd_flush = 1'b0; smp();
    vectors++; if (f_busy !== 1'b1) begin miscompares++; $display("FAIL drain.f_busy got %h want 1", f_busy); end
    vectors++; if (ibus_ren !== 1'b0) begin miscompares++; $display("FAIL drain.ibus_ren got %h want 0", ibus_ren); end
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL drain.f1_ready got %h want 0", f1_ready); end
    cyc(); smp();
    vectors++; if (f_busy !== 1'b1) begin miscompares++; $display("FAIL drain.f_busy2 got %h want 1", f_busy); end
    cyc(); ibus_busy = 1'b0; ibus_rdata = 32'h1234_5678;
    cyc(); ibus_busy = 1'b1; smp();
    vectors++; if ({f_busy, fd_valid} !== 2'b00) begin miscompares++; $display("FAIL drain.done got %b want 00", {f_busy, fd_valid}); end
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL drain.ready got %h want 1", f1_ready); end
    // Flush in the same cycle as completion drops the data without draining.
    f1_valid = 1'b1; f1_pc = 32'h400;
    cyc(); f1_valid = 1'b0; ibus_busy = 1'b0; fd_flush = 1'b1; ibus_rdata = 32'haaaa_5555;
    cyc(); fd_flush = 1'b0; ibus_busy = 1'b1; smp();
    vectors++; if ({f_busy, fd_valid} !== 2'b00) begin miscompares++; $display("FAIL flushdone.state got %b want 00", {f_busy, fd_valid}); end
  endtask

  task automatic test_stall_two();
    fd_stall = 1'b1; f1_valid = 1'b1; f1_pc = 32'h500; ibus_busy = 1'b1;
    cyc(); f1_valid = 1'b0; ibus_busy = 1'b0; ibus_rdata = 32'h0000_0a0a;
    cyc(); ibus_busy = 1'b1; f1_valid = 1'b1; f1_pc = 32'h504; smp();
`ifdef PIPE5_FETCH_SKID_EN
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL stall.skid_ready got %h want 1", f1_ready); end
    cyc(); f1_valid = 1'b0; ibus_busy = 1'b0; ibus_rdata = 32'h0000_0b0b;
    cyc(); ibus_busy = 1'b1; smp();
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL stall.full_ready got %h want 0", f1_ready); end
    vectors++; if (fd_pc !== 32'h500) begin miscompares++; $display("FAIL stall.head_pc got %h want 00000500", fd_pc); end
    cyc(); fd_stall = 1'b0;
    cyc(); smp();
`else
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL stall.full_ready got %h want 0", f1_ready); end
    cyc(); smp();
    vectors++; if (fd_pc !== 32'h500) begin miscompares++; $display("FAIL stall.head_pc got %h want 00000500", fd_pc); end
    vectors++; if (f1_ready !== 1'b0) begin miscompares++; $display("FAIL stall.still_blocked got %h want 0", f1_ready); end
    cyc(); fd_stall = 1'b0; smp();
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL stall.release_ready got %h want 1", f1_ready); end
    cyc(); f1_valid = 1'b0; ibus_busy = 1'b0; ibus_rdata = 32'h0000_0b0b;
    cyc(); ibus_busy = 1'b1; smp();
`endif
    vectors++; if (fd_pc !== 32'h504) begin miscompares++; $display("FAIL stall.second_pc got %h want 00000504", fd_pc); end
    vectors++; if (fd_instr !== 32'h0000_0b0b) begin miscompares++; $display("FAIL stall.second_instr got %h want 00000b0b", fd_instr); end
    cyc(); smp();
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL stall.empty got %h want 0", fd_valid); end
  endtask

  task automatic test_back_to_back();
    f1_valid = 1'b1; f1_pc = 32'h10a;
    cyc(); f1_pc = 32'h10e; smp();
    vectors++; if (f1_ready !== 1'b1) begin miscompares++; $display("FAIL b2b.ready_on_pop got %h want 1", f1_ready); end
    vectors++; if (fd_pc !== 32'h10a) begin miscompares++; $display("FAIL b2b.first_pc got %h want 0000010a", fd_pc); end
    cyc(); f1_valid = 1'b0; smp();
    vectors++; if ({fd_valid, mal_insn} !== 2'b11) begin miscompares++; $display("FAIL b2b.second_valid got %b want 11", {fd_valid, mal_insn}); end
    vectors++; if (fd_pc !== 32'h10e) begin miscompares++; $display("FAIL b2b.second_pc got %h want 0000010e", fd_pc); end
    cyc(); smp();
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b.empty got %h want 0", fd_valid); end
  endtask

  task automatic test_reset_mid_wait();
    f1_valid = 1'b1; f1_pc = 32'h600; ibus_busy = 1'b1;
    cyc(); f1_valid = 1'b0; nRST = 1'b0;
    cyc(); nRST = 1'b1; smp();
    vectors++; if ({ibus_ren, fd_valid, f_busy} !== 3'b000) begin miscompares++; $display("FAIL rstwait.outs got %b want 000", {ibus_ren, fd_valid, f_busy}); end
    vectors++; if (ibus_addr !== 32'h0) begin miscompares++; $display("FAIL rstwait.addr got %h want 0", ibus_addr); end
    cyc(); ibus_busy = 1'b0; ibus_rdata = 32'h7777_7777;
    cyc(); smp();
    vectors++; if ({fd_valid, f_busy} !== 2'b00) begin miscompares++; $display("FAIL rstwait.no_stale got %b want 00", {fd_valid, f_busy}); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_bus_error();
    test_flush_drain();
    test_stall_two();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
